// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated RAM.
// rr_pick finds the first requester at or above ptr, wrapping within num_ch channels.
package mem_arb_pkg;

  localparam int MAX_CH    = 8;
  localparam int MAX_PTR_W = 3;

  typedef enum logic {OP_RD, OP_WR} mem_op_e;

  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0]    req,
                                                input logic [MAX_PTR_W-1:0] ptr,
                                                input int                   num_ch);
    logic [MAX_CH-1:0]    grant;
    logic                 found;
    int                   sum;
    logic [MAX_PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      sum = int'(ptr) + i;
      if (sum >= num_ch) sum = sum - num_ch;
      idx = sum[MAX_PTR_W-1:0];
      if ((i < num_ch) && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first requester from i_ptr upward,
// and the pointer value that follows that grant.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [PTR_W-1:0]  o_next_ptr,
  output logic              o_any
);

  logic [MAX_CH-1:0] w_pick;
  logic              w_unused_pick;

  assign w_pick        = rr_pick(MAX_CH'(i_req), MAX_PTR_W'(i_ptr), NUM_CH);
  assign w_unused_pick = ^w_pick;
  assign o_grant       = w_pick[NUM_CH-1:0];
  assign o_any         = |o_grant;

  always_comb begin
    o_next_ptr = i_ptr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (o_grant[c]) o_next_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
    end
  end

endmodule

// File: rtl/mem_arb_ram.sv
// Single-port synchronous RAM shared by NUM_CH requesters through a round-robin
// arbiter; reads return on a per-channel strobe after RD_LAT cycles.
module mem_arb_ram
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     chip_en,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [NUM_CH-1:0] ONE_CH = NUM_CH'(1);

  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_next_ptr;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic              w_fire;
  logic [CH_W-1:0]   w_ch;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  mem_op_e           w_op;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_req = req_valid & {NUM_CH{chip_en}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req      (w_req),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr),
    .o_any      (w_fire)
  );

  assign req_ready = w_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_rr_ptr <= '0;
    else if (w_fire) r_rr_ptr <= w_next_ptr;
  end

  always_comb begin
    w_ch    = '0;
    w_addr  = '0;
    w_wdata = '0;
    w_op    = OP_RD;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_grant[c]) begin
        w_ch    = CH_W'(c);
        w_addr  = req_addr[c*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[c*DATA_W +: DATA_W];
        w_op    = req_write[c] ? OP_WR : OP_RD;
      end
    end
  end

  assign w_rd_fire = w_fire & (w_op == OP_RD);
  assign w_wr_fire = w_fire & (w_op == OP_WR);

  // Storage is deliberately left out of reset so it maps onto plain RAM cells.
  always_ff @(posedge clock) begin
    if (w_wr_fire) r_mem[w_addr] <= w_wdata;
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rsp_valid <= '0;
        rsp_rdata <= '0;
      end else begin
        rsp_valid <= w_rd_fire ? (ONE_CH << w_ch) : '0;
        if (w_rd_fire) rsp_rdata <= r_mem[w_addr];
      end
    end
  end else if (RD_LAT == 2) begin : g_lat2
    logic              r_s1_valid;
    logic [CH_W-1:0]   r_s1_ch;
    logic [DATA_W-1:0] r_s1_data;

    always_ff @(posedge clock) begin
      if (w_rd_fire) r_s1_data <= r_mem[w_addr];
    end

    // Only the valid/channel tag is reset, so a read in flight at reset is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_s1_valid <= 1'b0;
        r_s1_ch    <= '0;
        rsp_valid  <= '0;
        rsp_rdata  <= '0;
      end else begin
        r_s1_valid <= w_rd_fire;
        if (w_rd_fire) r_s1_ch <= w_ch;
        rsp_valid <= r_s1_valid ? (ONE_CH << r_s1_ch) : '0;
        if (r_s1_valid) rsp_rdata <= r_s1_data;
      end
    end
  end else begin : g_bad_lat
    $error("mem_arb_ram: RD_LAT must be 1 or 2, got %0d", RD_LAT);
  end

endmodule
